// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter: shares one L1 MMU line port among NCH client channels.
// One transaction runs at a time: IDLE picks a client, BUSY holds the MMU
// request until the matching done, RESP pulses the client's done bit.
// Optional build macro L1_ARB_FIXED_PRIORITY_EN: lowest-index client always
// wins. When it is undefined, arbitration is round-robin.
module l1_mmu_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    localparam int GW    = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        cl_req_read,
    input  logic [NCH-1:0]        cl_req_write,
    input  logic [NCH*ADDR_W-1:0] cl_req_addr,
    input  logic [NCH*LINE_W-1:0] cl_write_data,
    output logic [NCH-1:0]        cl_read_done,
    output logic [NCH-1:0]        cl_write_done,
    output logic [LINE_W-1:0]     cl_read_data,
    output logic                  mmu_req_read,
    output logic                  mmu_req_write,
    output logic [ADDR_W-1:0]     mmu_req_addr,
    output logic [LINE_W-1:0]     mmu_write_data,
    input  logic                  mmu_read_done,
    input  logic                  mmu_write_done,
    input  logic [LINE_W-1:0]     mmu_read_data,
    output logic                  busy,
    output logic [GW-1:0]         grant_id
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nx;
    logic [NCH-1:0]    pend;
    logic              any_pend;
    logic [GW-1:0]     sel;
    logic              op_wr;
    logic              xfer_done;
    logic [ADDR_W-1:0] addr_a [NCH];
    logic [LINE_W-1:0] data_a [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign addr_a[g] = cl_req_addr[g*ADDR_W +: ADDR_W];
        assign data_a[g] = cl_write_data[g*LINE_W +: LINE_W];
    end

    assign pend      = cl_req_read | cl_req_write;
    assign any_pend  = |pend;
    // Only a done of the same type as the request in flight ends BUSY.
    assign xfer_done = (mmu_req_read & mmu_read_done) | (mmu_req_write & mmu_write_done);

`ifdef L1_ARB_FIXED_PRIORITY_EN
    // Lowest-index pending channel wins (channel 0 is the icache).
    always_comb begin
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (pend[i]) sel = GW'(i);
    end
`else
    logic [GW-1:0] last_grant;

    // Round-robin: first pending channel after the last winner, wrapping.
    always_comb begin : rr_pick
        logic          found;
        logic [GW-1:0] c;
        sel   = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 1; k <= NCH; k++) begin
            c = GW'((int'(last_grant) + k) % NCH);
            if (!found && pend[c]) begin
                sel   = c;
                found = 1'b1;
            end
        end
    end

    // Remember the winner; reset value makes channel 0 win first.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)                       last_grant <= GW'(NCH - 1);
        else if (state == IDLE && any_pend) last_grant <= sel;
    end
`endif

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state, busy flag and the one-cycle client done pulse in RESP.
    always_comb begin
        state_nx      = state;
        busy          = 1'b1;
        cl_read_done  = '0;
        cl_write_done = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_pend) state_nx = BUSY;
            end
            BUSY: if (xfer_done) state_nx = RESP;
            RESP: begin
                state_nx = IDLE;
                if (op_wr) cl_write_done = NCH'(1) << grant_id;
                else       cl_read_done  = NCH'(1) << grant_id;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request registers: loaded at grant so client changes cannot disturb the
    // MMU; a write wins when a client raises read and write together.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mmu_req_read   <= 1'b0;
            mmu_req_write  <= 1'b0;
            mmu_req_addr   <= '0;
            mmu_write_data <= '0;
            op_wr          <= 1'b0;
            grant_id       <= '0;
            cl_read_data   <= '0;
        end else begin
            case (state)
                IDLE: if (any_pend) begin
                    grant_id       <= sel;
                    op_wr          <= cl_req_write[sel];
                    mmu_req_write  <= cl_req_write[sel];
                    mmu_req_read   <= ~cl_req_write[sel];
                    mmu_req_addr   <= addr_a[sel];
                    mmu_write_data <= data_a[sel];
                end
                BUSY: begin
                    if (mmu_req_read && mmu_read_done) begin
                        mmu_req_read <= 1'b0;
                        cl_read_data <= mmu_read_data;
                    end
                    if (mmu_req_write && mmu_write_done) mmu_req_write <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Bench for l1_mmu_arbiter (NCH=4). A transaction-level model drives
// clients and an MMU responder, predicts each grant from the arbitration
// rule and checks the DUT every cycle. Honours L1_ARB_FIXED_PRIORITY_EN.
module tb_l1_mmu_arbiter;
    localparam int NCH = 4, ADDR_W = 32, LINE_W = 256, GW = 2;

    logic                  sys_clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH-1:0]        cl_req_read = '0, cl_req_write = '0;
    logic [NCH*ADDR_W-1:0] cl_req_addr = '0;
    logic [NCH*LINE_W-1:0] cl_write_data = '0;
    logic [NCH-1:0]        cl_read_done, cl_write_done;
    logic [LINE_W-1:0]     cl_read_data;
    logic                  mmu_req_read, mmu_req_write;
    logic [ADDR_W-1:0]     mmu_req_addr;
    logic [LINE_W-1:0]     mmu_write_data;
    logic                  mmu_read_done = 1'b0, mmu_write_done = 1'b0;
    logic [LINE_W-1:0]     mmu_read_data = '0;
    logic                  busy;
    logic [GW-1:0]         grant_id;

    l1_mmu_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .cl_req_read(cl_req_read), .cl_req_write(cl_req_write),
        .cl_req_addr(cl_req_addr), .cl_write_data(cl_write_data),
        .cl_read_done(cl_read_done), .cl_write_done(cl_write_done),
        .cl_read_data(cl_read_data),
        .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write),
        .mmu_req_addr(mmu_req_addr), .mmu_write_data(mmu_write_data),
        .mmu_read_done(mmu_read_done), .mmu_write_done(mmu_write_done),
        .mmu_read_data(mmu_read_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    // Model state: phase 0 idle, 1 transfer outstanding, 2 done due.
    int vecs = 0, errs = 0, mph = 0, exp_ch = 0, last_g = NCH - 1, lat = 0;
    int lat_fix = -1, cyc = 0, rd_hi = 0, rd_pulses = 0, wr_pulses = 0;
    bit exp_wr = 0, auto_en = 0, corrupt = 0, rfix_en = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [LINE_W-1:0] exp_wdata = '0, exp_rdata = '0, rfix = '0;
    logic [NCH-1:0]    act = '0, a_rd = '0, a_wr = '0, cont = '0;
    logic [ADDR_W-1:0] a_addr [NCH];
    logic [LINE_W-1:0] a_data [NCH];
    int grants[$];
    int gcyc[$];

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Winner among pending channels, from the arbitration rule.
    function automatic int pick(logic [NCH-1:0] p);
`ifdef L1_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < NCH; i++) if (p[i]) return i;
`else
        for (int k = 1; k <= NCH; k++) if (p[(last_g + k) % NCH]) return (last_g + k) % NCH;
`endif
        return 0;
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < NCH; i++) begin
            cl_req_read[i]  = act[i] & a_rd[i];
            cl_req_write[i] = act[i] & a_wr[i];
            cl_req_addr[i*ADDR_W +: ADDR_W]   = (corrupt && i == exp_ch) ? ~a_addr[i] : a_addr[i];
            cl_write_data[i*LINE_W +: LINE_W] = (corrupt && i == exp_ch) ? ~a_data[i] : a_data[i];
        end
    endtask

    task automatic issue(int ch, bit rd, bit wr, logic [ADDR_W-1:0] ad, logic [LINE_W-1:0] d);
        act[ch] = 1'b1; a_rd[ch] = rd; a_wr[ch] = wr; a_addr[ch] = ad; a_data[ch] = d;
    endtask

    task automatic model_reset();
        mph = 0; last_g = NCH - 1; exp_rdata = '0; act = '0; cont = '0;
        corrupt = 0; lat = 0;
        mmu_read_done = 1'b0; mmu_write_done = 1'b0;
        for (int i = 0; i < NCH; i++) begin a_addr[i] = '0; a_data[i] = '0; end
        drive_clients();
    endtask

    // One clock: check outputs mid-cycle, then drive the next cycle's inputs.
    task automatic step();
        logic [NCH-1:0]     oh;
        logic [2*NCH+2:0]   es;
        int                 op;
        @(negedge sys_clk);
        cyc++;
        oh = NCH'(1) << exp_ch;
        rd_hi     += int'(mmu_req_read);
        rd_pulses += $countones(cl_read_done);
        wr_pulses += $countones(cl_write_done);
        case (mph)
            0: begin
                vecs++;
                if ({busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done} !== '0) begin
                    errs++; $display("FAIL idle_status: got %b expected 0", {busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done});
                end
                vecs++;
                if (cl_read_data !== exp_rdata) begin
                    errs++; $display("FAIL idle_rdata: got %h expected %h", cl_read_data, exp_rdata);
                end
            end
            1: begin
                es = {1'b1, !exp_wr, exp_wr, NCH'(0), NCH'(0)};
                vecs++;
                if ({busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done} !== es) begin
                    errs++; $display("FAIL busy_status: got %b expected %b", {busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done}, es);
                end
                vecs++;
                if (grant_id !== GW'(exp_ch)) begin
                    errs++; $display("FAIL grant_id: got %0d expected %0d", grant_id, exp_ch);
                end
                vecs++;
                if (mmu_req_addr !== exp_addr) begin
                    errs++; $display("FAIL mmu_addr: got %h expected %h", mmu_req_addr, exp_addr);
                end
                if (exp_wr) begin
                    vecs++;
                    if (mmu_write_data !== exp_wdata) begin
                        errs++; $display("FAIL mmu_wdata: got %h expected %h", mmu_write_data, exp_wdata);
                    end
                end
            end
            default: begin
                es = {3'b100, exp_wr ? NCH'(0) : oh, exp_wr ? oh : NCH'(0)};
                vecs++;
                if ({busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done} !== es) begin
                    errs++; $display("FAIL resp_status: got %b expected %b", {busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done}, es);
                end
                vecs++;
                if (cl_read_data !== exp_rdata) begin
                    errs++; $display("FAIL resp_rdata: got %h expected %h", cl_read_data, exp_rdata);
                end
            end
        endcase

        mmu_read_done = 1'b0; mmu_write_done = 1'b0; mmu_read_data = rnd_line(); corrupt = 0;
        for (int i = 0; i < NCH; i++) begin
            if (!act[i]) begin
                if (cont[i]) issue(i, 1, 0, $urandom, '0);
                else if (auto_en && $urandom_range(0, 3) == 0) begin
                    op = $urandom_range(0, 2);
                    issue(i, op != 1, op != 0, $urandom, rnd_line());
                end
            end
        end
        case (mph)
            0: if (act != '0) begin
                exp_ch = pick(act); last_g = exp_ch;
                exp_wr = a_wr[exp_ch]; exp_addr = a_addr[exp_ch]; exp_wdata = a_data[exp_ch];
                lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 4);
                grants.push_back(exp_ch); gcyc.push_back(cyc);
                mph = 1;
            end
            1: begin
                corrupt = auto_en && ($urandom_range(0, 1) == 1);
                if (lat == 0) begin
                    if (exp_wr) mmu_write_done = 1'b1;
                    else begin
                        mmu_read_done = 1'b1;
                        if (rfix_en) mmu_read_data = rfix;
                        exp_rdata = mmu_read_data;
                    end
                    mph = 2;
                end else begin
                    lat--;
                    if ($urandom_range(0, 2) == 0) begin
                        if (exp_wr) mmu_read_done = 1'b1;
                        else        mmu_write_done = 1'b1;
                    end
                end
            end
            default: begin act[exp_ch] = 1'b0; mph = 0; end
        endcase
        drive_clients();
    endtask

    task automatic run_until_idle(int maxc);
        int n = 0;
        while (!(mph == 0 && act == '0) && n < maxc) begin step(); n++; end
        if (n >= maxc) begin
            vecs++; errs++; $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, maxc);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk); rst = 1'b1; model_reset();
        @(negedge sys_clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        vecs++;
        if ({busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done, grant_id} !== '0) begin
            errs++; $display("FAIL reset_ctrl: got %b expected 0", {busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done, grant_id});
        end
        vecs++;
        if ({mmu_req_addr, mmu_write_data, cl_read_data} !== '0) begin
            errs++; $display("FAIL reset_data: got %h expected 0", {mmu_req_addr, mmu_write_data, cl_read_data});
        end
        @(negedge sys_clk); rst = 1'b0;
    endtask

    task automatic test_single_read();
        rd_hi = 0; rd_pulses = 0; lat_fix = 3; rfix_en = 1; rfix = {32{8'hA5}};
        issue(0, 1, 0, 32'h0000_1000, '0);
        run_until_idle(50);
        vecs++;
        if (rd_hi !== 4) begin errs++; $display("FAIL read_req_cycles: got %0d expected 4", rd_hi); end
        vecs++;
        if (rd_pulses !== 1) begin errs++; $display("FAIL read_done_pulses: got %0d expected 1", rd_pulses); end
        vecs++;
        if (cl_read_data !== {32{8'hA5}}) begin errs++; $display("FAIL read_line: got %h expected a5..", cl_read_data); end
        lat_fix = -1; rfix_en = 0;
    endtask

    task automatic test_rw_conflict();
        rd_pulses = 0; wr_pulses = 0;
        issue(1, 1, 1, 32'h40, rnd_line());
        run_until_idle(50);
        vecs++;
        if ({rd_pulses, wr_pulses} !== {32'd0, 32'd1}) begin
            errs++; $display("FAIL rw_conflict_pulses: got rd=%0d wr=%0d expected rd=0 wr=1", rd_pulses, wr_pulses);
        end
    endtask

    task automatic test_back_to_back();
        int n, seen1;
        grants.delete(); gcyc.delete();
        cont = 4'b0011;
        repeat (40) step();
        n = grants.size();
        vecs++;
        if (n < 8) begin errs++; $display("FAIL b2b_grant_count: got %0d expected >= 8", n); end
        for (int i = 1; i < n; i++) begin
            vecs++;
            if (gcyc[i] - gcyc[i-1] < 3) begin
                errs++; $display("FAIL b2b_gap: got %0d expected >= 3", gcyc[i] - gcyc[i-1]);
            end
            vecs++;
`ifdef L1_ARB_FIXED_PRIORITY_EN
            if (grants[i] !== 0) begin errs++; $display("FAIL b2b_fixed: got ch%0d expected ch0", grants[i]); end
`else
            if (grants[i] === grants[i-1]) begin errs++; $display("FAIL b2b_alternate: got ch%0d twice expected alternation", grants[i]); end
`endif
        end
        cont[0] = 1'b0;
        grants.delete();
        repeat (12) step();
        seen1 = 0;
        foreach (grants[i]) if (grants[i] == 1) seen1 = 1;
        vecs++;
        if (seen1 !== 1) begin errs++; $display("FAIL ch1_after_ch0_drops: got %0d expected 1", seen1); end
        cont = '0;
        run_until_idle(50);
    endtask

    task automatic test_four_ch();
        do_reset();
        grants.delete();
        issue(1, 1, 0, $urandom, '0);
        issue(3, 0, 1, $urandom, rnd_line());
        run_until_idle(60);
        vecs++;
        if (grants.size() != 2) begin
            errs++; $display("FAIL four_ch_count: got %0d expected 2", grants.size());
        end else if ({grants[0], grants[1]} !== {32'd1, 32'd3}) begin
            errs++; $display("FAIL four_ch_order: got %0d,%0d expected 1,3", grants[0], grants[1]);
        end
    endtask

    task automatic test_reset_mid();
        issue(1, 0, 1, 32'h80, rnd_line());
        lat_fix = 20;
        step(); step(); step();
        vecs++;
        if (mmu_req_write !== 1'b1) begin errs++; $display("FAIL mid_pre_write: got %b expected 1", mmu_req_write); end
        wr_pulses = 0;
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done} !== '0) begin
            errs++; $display("FAIL mid_reset_drop: got %b expected 0", {busy, mmu_req_read, mmu_req_write, cl_read_done, cl_write_done});
        end
        model_reset();
        lat_fix = -1;
        @(negedge sys_clk); rst = 1'b0;
        grants.delete();
        issue(0, 1, 0, $urandom, '0);
        issue(1, 1, 0, $urandom, '0);
        run_until_idle(60);
        vecs++;
        if (wr_pulses !== 0) begin errs++; $display("FAIL mid_no_done: got %0d expected 0", wr_pulses); end
        vecs++;
        if (grants.size() == 0 || grants[0] !== 0) begin
            errs++; $display("FAIL mid_next_grant: got %0d expected ch0", grants.size() ? grants[0] : -1);
        end
    endtask

    task automatic test_random();
        auto_en = 1;
        repeat (600) step();
        auto_en = 0;
        run_until_idle(300);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rw_conflict();
        test_back_to_back();
        test_four_ch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/l1_mmu_arbiter.md
L1_MMU_ARBITER -- requirements
Module: l1_mmu_arbiter

Interface
REQ-001 Parameter NCH, default 2, number of L1 client channels (legal range 2..8).
REQ-002 Parameter ADDR_W, default 32, request address width.
REQ-003 Parameter LINE_W, default 256, cache-line width.
REQ-004 Port sys_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port cl_req_read  input  NCH  per-channel line-read request.
REQ-007 Port cl_req_write  input  NCH  per-channel line-write request.
REQ-008 Port cl_req_addr  input  NCH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
REQ-009 Port cl_write_data  input  NCH*LINE_W  packed write lines; channel i at [i*LINE_W +: LINE_W].
REQ-010 Port cl_read_done  output  NCH  one-hot read-completion pulse.
REQ-011 Port cl_write_done  output  NCH  one-hot write-completion pulse.
REQ-012 Port cl_read_data  output  LINE_W  returned line, broadcast to all channels.
REQ-013 Port mmu_req_read / mmu_req_write  output  1 each  request to L1 MMU.
REQ-014 Port mmu_req_addr  output  ADDR_W; mmu_write_data  output  LINE_W.
REQ-015 Port mmu_read_done / mmu_write_done  input  1 each; mmu_read_data  input  LINE_W.
REQ-016 Port busy  output  1; grant_id  output  max(1,$clog2(NCH))  current owner.

Function
REQ-017 FSM states IDLE, BUSY, RESP; only IDLE samples new requests.
REQ-018 In IDLE, channel i is pending if cl_req_read[i] | cl_req_write[i]; with any pending, arbiter selects one, registers its op, address and write data, sets grant_id, and moves to BUSY.
REQ-019 Selection is round-robin: search starts at last_grant+1 modulo NCH and wraps; last_grant updates on every grant.
REQ-020 If a channel asserts read and write together, write is performed and read is dropped; no read_done is issued.
REQ-021 In BUSY, mmu_req_read/mmu_req_write/mmu_req_addr/mmu_write_data are driven from registers only, held stable until the matching MMU done.
REQ-022 MMU done of the wrong type in BUSY is ignored.
REQ-023 On matching MMU done in BUSY: capture mmu_read_data (reads), deassert MMU request next cycle, move to RESP.
REQ-024 In RESP, exactly the granted channel's done bit pulses high for one cycle; cl_read_data holds captured line from RESP until the next read capture.
REQ-025 RESP returns to IDLE unconditionally; grant-to-grant minimum 3 cycles.
REQ-026 Clients hold request, address and data until their done; they deassert in the cycle after done, so IDLE never re-grants a completed request.
REQ-027 Requests changing in BUSY/RESP have no effect on the transaction in flight.
REQ-028 busy is high in BUSY and RESP, low in IDLE.

Reset
REQ-029 On rst: state IDLE, mmu_req_read/mmu_req_write 0, mmu_req_addr 0, mmu_write_data 0, cl_read_done/cl_write_done 0, cl_read_data 0, grant_id 0, busy 0, last_grant NCH-1 (channel 0 wins first).
REQ-030 Reset mid-transaction abandons it with no done pulse; MMU request drops immediately (asynchronously).

Configuration
REQ-031 Macro L1_ARB_FIXED_PRIORITY_EN defined: lowest-index pending channel always wins (channel 0 = icache highest), last_grant unused.
REQ-032 Macro undefined: round-robin per REQ-019.

Verification
REQ-033 NCH=2, ch0 read 0x0000_1000, MMU done 4 cycles later with data 0xA5 repeated -> mmu_req_read high 4 cycles, cl_read_done[0] single pulse, cl_read_data = 0xA5 pattern.
REQ-034 Both channels read continuously (round-robin) -> grants alternate 0,1,0,1; each grant separated by >=3 cycles.
REQ-035 Same as REQ-034 with L1_ARB_FIXED_PRIORITY_EN -> ch0 granted every time while requesting; ch1 granted once ch0 drops.
REQ-036 ch1 asserts read+write to 0x40 -> only mmu_req_write issued, cl_write_done[1] pulses, cl_read_done stays 0.
REQ-037 rst asserted while BUSY with mmu_req_write high -> MMU request low same cycle, no done pulse, next grant goes to ch0.
REQ-038 NCH=4, channels 1 and 3 pending, last_grant=3 -> ch1 granted, then ch3.
